tm_rx_7seg9: RTL

Receiver/decoder for the two-wire TM1640-style serial stream (tm_clk/tm_din) that our 7seg9 display controller transmits. It parses start/stop framing, command and data bytes (LSB first), and reconstructs the 9-digit segment RAM, the brightness level and the display-on flag. It is used as a loopback checker and bench model alongside the display controller, and as a snoop on the PMOD lines.

---
 rtl/tm_rx_7seg9.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/tm_rx_7seg9.sv
// Receiver for the two-wire TM1640-style stream: synchronizes tm_clk/tm_din, decodes
// start/stop framing and LSB-first bytes, and rebuilds segment RAM, brightness and on flag.
module tm_rx_7seg9 #(
  parameter int DIGITS      = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tm_clk,
  input  logic                  tm_din,
  output logic [8*DIGITS-1:0]   led_data_packed,
  output logic [2:0]            level,
  output logic                  on,
  output logic                  byte_valid,
  output logic [7:0]            rx_byte,
  output logic                  frame_done,
  output logic                  proto_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_h_q;
  logic                   sdin_h_q;
  logic [2:0]             cnt_q;
  logic [7:0]             shift_q;
  logic [3:0]             addr_q;
  logic                   fixed_q;
  logic [8*DIGITS-1:0]    shadow_q;
  logic [8*DIGITS-1:0]    led_q;
  logic [2:0]             level_q;
  logic                   on_q;
  logic                   byte_valid_q;
  logic [7:0]             rx_byte_q;
  logic                   frame_done_q;
  logic                   proto_err_q;

  logic       sclk;
  logic       sdin;
  logic       rise;
  logic       start_evt;
  logic       stop_evt;
  logic [7:0] byte_d;

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdin = din_sync_q[SYNC_STAGES-1];

  // Start/stop need sclk high in both this and the previous cycle, so a data change
  // coinciding with a rising sclk is always treated as a bit sample instead.
  assign rise      = sclk & ~sclk_h_q;
  assign start_evt = sclk & sclk_h_q &  sdin_h_q & ~sdin;
  assign stop_evt  = sclk & sclk_h_q & ~sdin_h_q &  sdin;

  always_comb begin
    byte_d        = shift_q;
    byte_d[cnt_q] = sdin;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      clk_sync_q   <= '0;
      din_sync_q   <= '0;
      sclk_h_q     <= 1'b0;
      sdin_h_q     <= 1'b0;
      cnt_q        <= 3'd0;
      shift_q      <= 8'd0;
      addr_q       <= 4'd0;
      fixed_q      <= 1'b0;
      shadow_q     <= '0;
      led_q        <= '0;
      level_q      <= 3'd0;
      on_q         <= 1'b0;
      byte_valid_q <= 1'b0;
      rx_byte_q    <= 8'd0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
    end else begin
      clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], tm_clk};
      din_sync_q   <= {din_sync_q[SYNC_STAGES-2:0], tm_din};
      sclk_h_q     <= sclk;
      sdin_h_q     <= sdin;
      byte_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      proto_err_q  <= 1'b0;

      if (stop_evt && state_q != IDLE) begin
        led_q        <= shadow_q;
        frame_done_q <= 1'b1;
        proto_err_q  <= (cnt_q != 3'd0);
        cnt_q        <= 3'd0;
        state_q      <= IDLE;
      end else if (start_evt) begin
        if (state_q != IDLE)
          proto_err_q <= (cnt_q != 3'd0);
        cnt_q   <= 3'd0;
        state_q <= CMD;
      end else if (rise && state_q != IDLE) begin
        shift_q <= byte_d;
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
          rx_byte_q    <= byte_d;
          case (state_q)
            CMD: begin
              case (byte_d[7:6])
                2'b01: begin
                  fixed_q <= byte_d[2];
                  state_q <= SKIP;
                end
                2'b11: begin
                  addr_q  <= byte_d[3:0];
                  state_q <= DATA;
                end
                2'b10: begin
                  level_q <= byte_d[2:0];
                  on_q    <= byte_d[3];
                  state_q <= SKIP;
                end
                default: begin
                  proto_err_q <= 1'b1;
                  state_q     <= SKIP;
                end
              endcase
            end
            DATA: begin
              // Addresses at or beyond DIGITS match no slot and the byte is dropped.
              for (int k = 0; k < DIGITS; k++) begin
                if (addr_q == 4'(k))
                  shadow_q[8*k +: 8] <= byte_d;
              end
              if (!fixed_q)
                addr_q <= addr_q + 4'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign led_data_packed = led_q;
  assign level           = level_q;
  assign on              = on_q;
  assign byte_valid      = byte_valid_q;
  assign rx_byte         = rx_byte_q;
  assign frame_done      = frame_done_q;
  assign proto_err       = proto_err_q;

endmodule
